if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the IF/ID pipeline register. Keeps the fetch PC and
//  requests one 32-bit word (two 16-bit instructions) per access from instruction memory.
//  Fetched words go into a small prefetch queue. Each cycle the queue head is presented as
//  instr_set1/instr_set2/pc to IF/ID. The unit handles hazard stalls, branch redirects and
//  exception-vector redirects.
// PARAMETERS
//  DEPTH       2             prefetch queue entries (power of 2, >=2)
//  RESET_PC    32'h0000_0000 fetch address after reset
//  EXC_VECTOR  32'h0000_0040 fetch address taken on exception
//  NOP         16'h0000      bubble encoding driven when no valid instruction is available
// PORTS
//  clk          in   1   clock; all state updates on negedge, the same edge as the pipeline registers
//  reset        in   1   reset, synchronous, active-high
//  imem_req     out  1   instruction memory request
//  imem_addr    out  32  word-aligned request address (bits[1:0]=0)
//  imem_ack     in   1   request accepted; imem_rdata is valid in this same cycle
//  imem_rdata   in   32  [15:0]=instr at addr, [31:16]=instr at addr+2
//  if_write     in   1   IF/ID load enable from the hazard unit; 1 = consume the queue head this cycle
//  redirect     in   1   branch/jump taken; restart fetch at redirect_pc
//  redirect_pc  in   32  halfword-aligned target
//  exception    in   1   restart fetch at EXC_VECTOR; has priority over redirect
//  instr_set1   out  16  first instruction of the head pair
//  instr_set2   out  16  second instruction of the head pair
//  pc           out  32  halfword address of instr_set1
//  fetch_valid  out  1   head entry is valid
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC; queue empty; imem_req=0; imem_addr=0; instr_set1/2=NOP; pc=0;
//    fetch_valid=0; drop flag cleared. Reset during an outstanding request abandons that request.
//  Request rule: at most one request outstanding. Raise imem_req when (count + outstanding) < DEPTH
//    and the drop flag is clear. Hold imem_req and imem_addr stable until imem_ack is sampled 1.
//    imem_req may rise again in the cycle after the ack.
//  On ack with no flush: push {fetch_pc, imem_rdata}; fetch_pc += 4 (wraps modulo 2^32).
//  Outputs are combinational from the queue head:
//    - queue empty: fetch_valid=0, instrs=NOP, pc=fetch_pc.
//    - queue non-empty: fetch_valid=1, entry data shown.
//  Pop: if_write=1 and queue non-empty pops the head. if_write=0 holds the head unchanged, and fetch
//    continues until the queue is full. Push and pop in the same cycle leave count unchanged.
//  Flush (redirect|exception): queue cleared; new target = EXC_VECTOR if exception, else redirect_pc.
//    fetch_pc <= {target[31:2],2'b00}; skip_lo <= target[1].
//    Any pop in the same cycle is ignored.
//  Outstanding request at flush: the request must still complete; set the drop flag and discard that
//    ack's data. The new fetch is issued after the ack. An ack arriving in the flush cycle itself is
//    discarded with no drop flag.
//  skip_lo: the first word pushed after the flush has instr_set1 forced to NOP and pc = word+2;
//    skip_lo then clears.
//  A flush while the queue is full, or during a stall, behaves identically; flush is never blocked by
//    if_write.
//  Queue pointers are log2(DEPTH) bits wide and wrap; count ranges 0..DEPTH.
// STRUCTURE
//  Shared package: NOP encoding, RESET_PC, EXC_VECTOR, and the fetch-entry typedef {pc[31:0],
//    word[31:0]}.
//  One sub-module, fetch_queue: synchronous FIFO with push, pop, clear, head, count.
//  The top level holds fetch_pc, the outstanding/drop/skip_lo flags and the request logic.
// TESTING
//  1 Reset release, ack each request with 1-cycle latency, if_write=1: pairs at pc=0,4,8 with
//    fetch_valid=1. Before the first ack: instrs=0x0000 and fetch_valid=0.
//  2 if_write=0 for 5 cycles: at most 2 acks accepted, then imem_req=0; head stays pc=0.
//    Set if_write=1: pc=0,4 drain in consecutive cycles, then fetching resumes.
//  3 Redirect to 0x102 while a request is outstanding (ack delayed 3 cycles): the stale ack data
//    never appears. Next imem_addr=0x100; first pair has instr_set1=0x0000 and pc=0x102.
//  4 exception and redirect asserted in the same cycle: imem_addr=0x40, redirect_pc ignored.
//  5 Redirect in the same cycle as an ack and a pop: queue empty next cycle, fetch_valid=0,
//    the ack data is discarded.
//  6 RESET_PC=32'hFFFF_FFFC: the fetch after the first word wraps to 0x0000_0000.
//    Reset asserted mid-request: imem_req=0 next cycle and all outputs take their reset values.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared constants and fetch-entry type for the fetch stage
package if_fetch_unit_pkg;

  localparam logic [15:0] NOP_INSTR      = 16'h0000;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0040;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// rtl/if_fetch_unit_fetch_queue.sv - prefetch FIFO with push, pop, clear, head and count
module fetch_queue
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         clear_i,
  output fetch_entry_t head_o,
  output logic [PW:0]  count_o
);

  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [PW:0]     count_q;
  logic            push_ok;
  logic            pop_ok;

  assign push_ok = push_i && (count_q != DEPTH_C);
  assign pop_ok  = pop_i && (count_q != '0);

  always_ff @(negedge clk) begin
    if (reset || clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: fetch PC, memory request logic and prefetch queue
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int          DEPTH      = 2,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [15:0] NOP        = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        if_write,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exception,
  output logic [15:0] instr_set1,
  output logic [15:0] instr_set2,
  output logic [31:0] pc,
  output logic        fetch_valid
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          outstanding_q, outstanding_d;
  logic          drop_q, drop_d;
  logic          skip_lo_q, skip_lo_d;

  logic          flush;
  logic [31:0]   target;
  logic          accept;
  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  assign flush  = redirect | exception;
  assign target = exception ? EXC_VECTOR : redirect_pc;
  assign accept = outstanding_q & imem_ack;
  // Data of a request issued before a flush is discarded; so is an ack landing on the flush cycle.
  assign push   = accept & ~flush & ~drop_q;
  assign pop    = if_write & (count != '0) & ~flush;

  assign count_next = flush ? '0 : (count + CW'(push) - CW'(pop));

  always_comb begin
    push_entry.pc   = skip_lo_q ? (fetch_pc_q + 32'd2) : fetch_pc_q;
    push_entry.word = {imem_rdata[31:16], skip_lo_q ? NOP : imem_rdata[15:0]};
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .clear_i     (flush),
    .head_o      (head),
    .count_o     (count)
  );

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    skip_lo_d     = skip_lo_q;
    addr_d        = addr_q;
    outstanding_d = outstanding_q;
    drop_d        = (drop_q | (flush & outstanding_q)) & ~accept;
    if (flush) begin
      fetch_pc_d = word_align(target);
      skip_lo_d  = target[1];
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      skip_lo_d  = 1'b0;
    end
    // A new request is only launched once the previous one has been acked.
    if (!outstanding_q || imem_ack) begin
      outstanding_d = (count_next < DEPTH_C) && !drop_d;
      if (outstanding_d) begin
        addr_d = fetch_pc_d;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      addr_q        <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      skip_lo_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      addr_q        <= addr_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      skip_lo_q     <= skip_lo_d;
    end
  end

  assign imem_req    = outstanding_q;
  assign imem_addr   = addr_q;
  assign fetch_valid = (count != '0);
  assign instr_set1  = fetch_valid ? head.word[15:0]  : NOP;
  assign instr_set2  = fetch_valid ? head.word[31:16] : NOP;
  assign pc          = fetch_valid ? head.pc : fetch_pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - randomized scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset, imem_req, imem_ack, if_write, redirect, exception, fetch_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, pc;
  logic [15:0] instr_set1, instr_set2;

  logic        w_reset, w_imem_req, w_imem_ack, w_fetch_valid;
  logic [31:0] w_imem_addr, w_pc;
  logic [15:0] w_instr_set1, w_instr_set2;

  always #5 clk = ~clk;

  if_fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_write(if_write),
    .redirect(redirect), .redirect_pc(redirect_pc), .exception(exception),
    .instr_set1(instr_set1), .instr_set2(instr_set2), .pc(pc), .fetch_valid(fetch_valid)
  );

  assign w_imem_ack = w_imem_req;

  if_fetch_unit #(.DEPTH(2), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(w_reset), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ack(w_imem_ack), .imem_rdata(32'hABCD_1234), .if_write(1'b1),
    .redirect(1'b0), .redirect_pc(32'h0), .exception(1'b0),
    .instr_set1(w_instr_set1), .instr_set2(w_instr_set2), .pc(w_pc), .fetch_valid(w_fetch_valid)
  );

  typedef struct {
    logic [31:0] pc;
    logic [15:0] i1;
    logic [15:0] i2;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_pops = 0;
  bit          mon_en = 1'b0;
  logic [31:0] m_pc;
  bit          m_skip, m_drop;
  int          wait_cnt, lat, acks_acc;
  logic [31:0] held_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: compares the presented head against the expected stream every cycle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        if (sb.size() == DEPTH) chk("full_no_req", 32'(imem_req), 32'd0);
        if (sb.size() == 0) begin
          chk("empty_valid", 32'(fetch_valid), 32'd0);
          chk("empty_i1", 32'(instr_set1), 32'(NOP_INSTR));
          chk("empty_i2", 32'(instr_set2), 32'(NOP_INSTR));
          chk("empty_pc", pc, m_pc);
        end else begin
          chk("head_valid", 32'(fetch_valid), 32'd1);
          chk("head_pc", pc, sb[0].pc);
          chk("head_i1", 32'(instr_set1), 32'(sb[0].i1));
          chk("head_i2", 32'(instr_set2), 32'(sb[0].i2));
          if (if_write && !redirect && !exception) begin
            void'(sb.pop_front());
            n_pops++;
          end
        end
      end
    end
  end

  task automatic model_reset();
    sb.delete();
    m_pc     = RESET_PC_DEF;
    m_skip   = 1'b0;
    m_drop   = 1'b0;
    wait_cnt = 0;
  endtask

  task automatic do_reset(input int n);
    mon_en    = 1'b0;
    reset     = 1'b1;
    imem_ack  = 1'b0;
    if_write  = 1'b0;
    redirect  = 1'b0;
    exception = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    model_reset();
    mon_en = 1'b1;
  endtask

  // Called at posedge+1: drives one cycle, acts as memory, then updates the reference model.
  task automatic drive(input bit wr, input bit rd, input bit ex, input logic [31:0] tgt);
    bit          ack;
    bit          fl;
    logic [31:0] rdata;
    logic [31:0] new_tgt;
    exp_t        e;
    if_write    = wr;
    redirect    = rd;
    exception   = ex;
    redirect_pc = tgt;
    ack         = 1'b0;
    if (imem_req) begin
      if (wait_cnt > 0) chk("addr_stable", imem_addr, held_addr);
      held_addr = imem_addr;
      if (wait_cnt >= lat) begin
        ack      = 1'b1;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    rdata      = $urandom;
    imem_ack   = ack;
    imem_rdata = rdata;
    #2;
    fl = rd | ex;
    if (ack) begin
      if (m_drop) begin
        m_drop = 1'b0;
      end else if (!fl) begin
        chk("req_addr", imem_addr, m_pc);
        e.pc = m_skip ? m_pc + 32'd2 : m_pc;
        e.i1 = m_skip ? NOP_INSTR : rdata[15:0];
        e.i2 = rdata[31:16];
        sb.push_back(e);
        m_pc   = m_pc + 32'd4;
        m_skip = 1'b0;
        acks_acc++;
      end
    end
    if (fl) begin
      new_tgt = ex ? EXC_VECTOR_DEF : tgt;
      sb.delete();
      m_pc   = {new_tgt[31:2], 2'b00};
      m_skip = new_tgt[1];
      if (imem_req && !ack) m_drop = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w_addrs[$];
    logic [31:0] w_pcs[$];
    int          guard;
    reset = 1'b1; w_reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    if_write = 1'b0; redirect = 1'b0; exception = 1'b0; redirect_pc = '0;
    lat = 0; acks_acc = 0; held_addr = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset(3);

    // Streaming with immediate acks
    repeat (12) drive(1, 0, 0, 32'h0);

    // Stall: queue fills, request stops, head held
    do_reset(2);
    acks_acc = 0;
    repeat (5) drive(0, 0, 0, 32'h0);
    chk("stall_acks_le2", 32'(acks_acc <= 2), 32'd1);
    chk("stall_req_low", 32'(imem_req), 32'd0);
    chk("stall_head_pc", pc, 32'h0);
    repeat (6) drive(1, 0, 0, 32'h0);

    // Redirect with an outstanding slow request
    lat = 3;
    guard = 0;
    while (!(imem_req && wait_cnt == 1) && guard < 20) begin
      drive(1, 0, 0, 32'h0);
      guard++;
    end
    chk("redir_wait_timeout", 32'(guard < 20), 32'd1);
    drive(1, 1, 0, 32'h0000_0102);
    repeat (8) drive(1, 0, 0, 32'h0);
    lat = 0;
    repeat (6) drive(1, 0, 0, 32'h0);

    // Exception wins over redirect
    drive(1, 1, 1, 32'h0000_3336);
    repeat (8) drive(1, 0, 0, 32'h0);

    // Redirect coinciding with ack and pop
    guard = 0;
    while (!(imem_req && sb.size() > 0) && guard < 20) begin
      drive(1, 0, 0, 32'h0);
      guard++;
    end
    chk("ackpop_wait_timeout", 32'(guard < 20), 32'd1);
    drive(1, 1, 0, 32'h0000_0200);
    chk("ackpop_empty", 32'(fetch_valid), 32'd0);
    repeat (8) drive(1, 0, 0, 32'h0);

    // Randomized traffic
    n_pops = 0;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 50) == 0) lat = $urandom_range(0, 3);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0,
            $urandom & 32'h0000_FFFE);
    end
    chk("random_progress", 32'(n_pops > 300), 32'd1);

    // Reset while a request is outstanding
    lat = 5;
    guard = 0;
    while (!(imem_req && wait_cnt == 2) && guard < 20) begin
      drive(1, 0, 0, 32'h0);
      guard++;
    end
    chk("rst_wait_timeout", 32'(guard < 20), 32'd1);
    mon_en = 1'b0; reset = 1'b1; imem_ack = 1'b0;
    if_write = 1'b0; redirect = 1'b0; exception = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(fetch_valid), 32'd0);
    chk("rst_i1", 32'(instr_set1), 32'(NOP_INSTR));
    chk("rst_i2", 32'(instr_set2), 32'(NOP_INSTR));
    chk("rst_pc", pc, 32'h0);
    reset = 1'b0;
    model_reset();
    mon_en = 1'b1;
    lat = 0;
    repeat (8) drive(1, 0, 0, 32'h0);
    mon_en = 1'b0;

    // Fetch PC wraps from the top of the address space
    chk("wrap_rst_req", 32'(w_imem_req), 32'd0);
    chk("wrap_rst_valid", 32'(w_fetch_valid), 32'd0);
    w_reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (w_imem_req) w_addrs.push_back(w_imem_addr);
      if (w_fetch_valid) begin
        w_pcs.push_back(w_pc);
        chk("wrap_i1", 32'(w_instr_set1), 32'h1234);
        chk("wrap_i2", 32'(w_instr_set2), 32'hABCD);
      end
    end
    chk("wrap_nreq", 32'(w_addrs.size() >= 2), 32'd1);
    chk("wrap_npc", 32'(w_pcs.size() >= 2), 32'd1);
    if (w_addrs.size() >= 2) begin
      chk("wrap_addr0", w_addrs[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", w_addrs[1], 32'h0000_0000);
    end
    if (w_pcs.size() >= 2) begin
      chk("wrap_pc0", w_pcs[0], 32'hFFFF_FFFC);
      chk("wrap_pc1", w_pcs[1], 32'h0000_0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
